// File: rtl/spi_miso_tx_4mb.sv
// SPI slave read-path engine (mode 0). Tracks the SPI frame independently of the
// write path, decodes read commands, snapshots the addressed register and shifts
// it out MSB-first on MISO. Never writes registers.
//
// Ports:
//   clk_100m, rst_n_syn            system clock, async active-low reset
//   spi_sclk, spi_cs_n, spi_mosi   SPI pins (async to clk_100m)
//   *_reg (10 x 32)                readable register values
//   spi_miso, spi_miso_oe          serial read data and its tristate enable
//   rd_strobe                      one-cycle pulse when a snapshot is taken
//   rd_addr                        address of the last snapshot
//   frame_err_cnt                  saturating count of aborted frames
module spi_miso_tx_4mb #(
  parameter logic [7:0]  OPC_READ         = 8'h0B,
  parameter logic [15:0] ADDR_VER         = 16'h0000,
  parameter logic [15:0] ADDR_REV_DATA    = 16'h0001,
  parameter logic [15:0] ADDR_DIP_SW      = 16'h0002,
  parameter logic [15:0] ADDR_BUTTONS     = 16'h0003,
  parameter logic [15:0] ADDR_BUTTONS_LED = 16'h0004,
  parameter logic [15:0] ADDR_DRAPE       = 16'h0005,
  parameter logic [15:0] ADDR_SPARE0      = 16'h0006,
  parameter logic [15:0] ADDR_SPARE1      = 16'h0007,
  parameter logic [15:0] ADDR_ADC_ALERTS  = 16'h0008,
  parameter logic [15:0] ADDR_FAULTS      = 16'h0009,
  parameter logic [31:0] UNMAPPED_VAL     = 32'hBAD0_ADD0
) (
  input  logic        clk_100m,
  input  logic        rst_n_syn,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  input  logic [31:0] ver_reg,
  input  logic [31:0] rev_data_reg,
  input  logic [31:0] dip_sw_reg,
  input  logic [31:0] buttons_reg,
  input  logic [31:0] buttons_led_reg,
  input  logic [31:0] drape_sensor_reg,
  input  logic [31:0] spare0_io_reg,
  input  logic [31:0] spare1_io_reg,
  input  logic [31:0] ADC_Alerts_reg,
  input  logic [31:0] Fault_Flages_reg,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        rd_strobe,
  output logic [15:0] rd_addr,
  output logic [7:0]  frame_err_cnt
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned HDR_W  = 23;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DATA, SKIP, DONE} state_t;

  // Pin synchronizers; the third sclk stage provides edge detection
  logic [2:0] sclk_s;
  logic [1:0] cs_s;
  logic [1:0] mosi_s;

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      sclk_s <= 3'b000;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_sclk};
      cs_s   <= {cs_s[0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_high, mosi_bit;
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign cs_high   = cs_s[1];
  assign mosi_bit  = mosi_s[1];

  // Register map lookup for the snapshot
  function automatic logic [DATA_W-1:0] reg_mux(input logic [15:0] a);
    logic [DATA_W-1:0] v;
    v = UNMAPPED_VAL;
    if (a == ADDR_VER)         v = ver_reg;
    if (a == ADDR_REV_DATA)    v = rev_data_reg;
    if (a == ADDR_DIP_SW)      v = dip_sw_reg;
    if (a == ADDR_BUTTONS)     v = buttons_reg;
    if (a == ADDR_BUTTONS_LED) v = buttons_led_reg;
    if (a == ADDR_DRAPE)       v = drape_sensor_reg;
    if (a == ADDR_SPARE0)      v = spare0_io_reg;
    if (a == ADDR_SPARE1)      v = spare1_io_reg;
    if (a == ADDR_ADC_ALERTS)  v = ADC_Alerts_reg;
    if (a == ADDR_FAULTS)      v = Fault_Flages_reg;
    return v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HDR_W-1:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               miso_d, oe_d, strobe_d;
  logic [15:0]        addr_d;
  logic [7:0]         err_d;
  logic [15:0]        addr_w;
  logic [7:0]         opc_w;

  // State and registered outputs
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hdr_q         <= '0;
      shift_q       <= '0;
      spi_miso      <= 1'b0;
      spi_miso_oe   <= 1'b0;
      rd_strobe     <= 1'b0;
      rd_addr       <= 16'h0000;
      frame_err_cnt <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hdr_q         <= hdr_d;
      shift_q       <= shift_d;
      spi_miso      <= miso_d;
      spi_miso_oe   <= oe_d;
      rd_strobe     <= strobe_d;
      rd_addr       <= addr_d;
      frame_err_cnt <= err_d;
    end
  end

  // Next-state and output logic; cs_n high overrides any SCLK edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    shift_d  = shift_q;
    miso_d   = spi_miso;
    oe_d     = spi_miso_oe;
    strobe_d = 1'b0;
    addr_d   = rd_addr;
    err_d    = frame_err_cnt;
    addr_w   = {hdr_q[14:0], mosi_bit};
    opc_w    = hdr_q[22:15];

    if (cs_high) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
      if (cnt_q != CNT_W'(0) && cnt_q != CNT_W'(56) && frame_err_cnt != 8'hFF)
        err_d = frame_err_cnt + 8'd1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = OPCODE;
          cnt_d   = '0;
        end
        OPCODE: if (sclk_rise) begin
          hdr_d = {hdr_q[HDR_W-2:0], mosi_bit};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) state_d = ADDR;
        end
        ADDR: if (sclk_rise) begin
          hdr_d = {hdr_q[HDR_W-2:0], mosi_bit};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(23)) begin
            if (opc_w == OPC_READ) begin
              state_d  = DATA;
              shift_d  = reg_mux(addr_w);
              addr_d   = addr_w;
              strobe_d = 1'b1;
              oe_d     = 1'b1;
            end else begin
              state_d = SKIP;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(55)) begin
              state_d = DONE;
              miso_d  = 1'b0;
            end
          end else if (sclk_fall) begin
            miso_d  = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
          end
        end
        SKIP: begin
          // Keep counting so a complete non-read frame is not seen as aborted
          miso_d = 1'b0;
          if (sclk_rise && cnt_q != CNT_W'(56)) cnt_d = cnt_q + CNT_W'(1);
        end
        DONE: miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
